// File: rtl/spike_rate_encoder_pkg.sv
// Shared constants, encodings and helpers for the spike rate encoder.
package snn_enc_pkg;

    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

    // Per-step coding mode, sampled on every step.
    typedef enum logic {
        MODE_SD   = 1'b0,
        MODE_LFSR = 1'b1
    } enc_mode_e;

    // Load sequencer: filling the shadow bank, or one cycle of shadow->active commit.
    typedef enum logic {
        LOAD_FILL   = 1'b0,
        LOAD_COMMIT = 1'b1
    } load_state_e;

    // One step of the right-shifting Galois LFSR; a non-zero state never maps to zero.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_advance(input logic [LFSR_WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    // Rotate left within the LFSR width; used to decorrelate channels sharing one LFSR.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_rotl(input logic [LFSR_WIDTH-1:0] v,
                                                        input int unsigned r);
        int unsigned rr;
        rr = r % LFSR_WIDTH;
        if (rr == 0)
            return v;
        return (v << rr) | (v >> (LFSR_WIDTH - rr));
    endfunction

endpackage

// File: rtl/spike_rate_encoder_channel.sv
// One encoder channel: sigma-delta accumulator with carry-out spike, plus
// the comparator used for stochastic (LFSR) coding.
module spike_enc_channel
    import snn_enc_pkg::*;
#(
    parameter int unsigned VALUE_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VALUE_BITS-1:0] value,
    input  logic [VALUE_BITS-1:0] rnd,
    input  logic                  mode,
    input  logic                  step,
    input  logic                  clear,
    output logic                  spike
);

    logic [VALUE_BITS-1:0] acc;
    logic [VALUE_BITS:0]   sum;
    enc_mode_e             cur_mode;

    // Decode the raw mode bit and form the widened accumulator sum.
    always_comb begin
        cur_mode = enc_mode_e'(mode);
        sum      = {1'b0, acc} + {1'b0, value};
    end

    // Spike this channel would emit if a step is taken now.
    always_comb begin
        if (cur_mode == MODE_LFSR)
            spike = (value > rnd);
        else
            spike = sum[VALUE_BITS];
    end

    // Accumulator advances only on sigma-delta steps; clear wins over step.
    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (step && (cur_mode == MODE_SD))
            acc <= sum[VALUE_BITS-1:0];
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder front end: serial byte load into a shadow bank, atomic commit
// to the active bank, and one spike vector per step via sigma-delta or LFSR coding.
module spike_rate_encoder
    import snn_enc_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 8,
    parameter int unsigned VALUE_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [VALUE_BITS-1:0] load_data,
    output logic                  load_ready,
    input  logic                  step,
    input  logic                  mode,
    input  logic                  clear,
    output logic [N_CHANNELS-1:0] spikes_out,
    output logic                  spikes_valid,
    output logic                  period_done
);

    localparam int unsigned IDX_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    logic [VALUE_BITS-1:0] shadow [N_CHANNELS];
    logic [VALUE_BITS-1:0] active [N_CHANNELS];
    logic [VALUE_BITS-1:0] rnd    [N_CHANNELS];
    logic [IDX_W-1:0]      load_idx;
    load_state_e           load_state;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic [VALUE_BITS-1:0] step_cnt;
    logic [N_CHANNELS-1:0] spike_vec;
    logic                  accept;

    // Bytes are refused only during the commit cycle; clear also blocks acceptance.
    always_comb begin
        load_ready = (load_state == LOAD_FILL);
        accept     = load_valid && load_ready && !clear;
    end

    // Load sequencer: fill shadow by index, then spend one cycle copying it to active.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_state <= LOAD_FILL;
            load_idx   <= '0;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else if (clear) begin
            load_state <= LOAD_FILL;
            load_idx   <= '0;
        end else begin
            case (load_state)
                LOAD_FILL: begin
                    if (accept) begin
                        shadow[load_idx] <= load_data;
                        if (load_idx == IDX_W'(N_CHANNELS - 1)) begin
                            load_idx   <= '0;
                            load_state <= LOAD_COMMIT;
                        end else begin
                            load_idx <= load_idx + 1'b1;
                        end
                    end
                end
                LOAD_COMMIT: begin
                    for (int unsigned i = 0; i < N_CHANNELS; i++)
                        active[i] <= shadow[i];
                    load_state <= LOAD_FILL;
                end
                default: load_state <= LOAD_FILL;
            endcase
        end
    end

    // Per-channel encoders; each sees the shared LFSR rotated by 2*i.
    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        logic [LFSR_WIDTH-1:0] rot;

        always_comb begin
            rot    = lfsr_rotl(lfsr, 2 * g);
            rnd[g] = rot[VALUE_BITS-1:0];
        end

        spike_enc_channel #(
            .VALUE_BITS(VALUE_BITS)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .value (active[g]),
            .rnd   (rnd[g]),
            .mode  (mode),
            .step  (step),
            .clear (clear),
            .spike (spike_vec[g])
        );
    end

    // Step sequencing: register the spike vector, advance LFSR and period counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr         <= LFSR_SEED;
            step_cnt     <= '0;
            spikes_out   <= '0;
            spikes_valid <= 1'b0;
            period_done  <= 1'b0;
        end else if (clear) begin
            lfsr         <= LFSR_SEED;
            step_cnt     <= '0;
            spikes_valid <= 1'b0;
            period_done  <= 1'b0;
        end else if (step) begin
            spikes_out   <= spike_vec;
            spikes_valid <= 1'b1;
            period_done  <= (step_cnt == '1);
            step_cnt     <= step_cnt + 1'b1;
            lfsr         <= lfsr_advance(lfsr);
        end else begin
            spikes_valid <= 1'b0;
            period_done  <= 1'b0;
        end
    end

endmodule
